vga_scan_engine: RTL and testbench
==================================

// Module: vga_scan_engine
// PURPOSE
// Parametrised VGA scan engine: generates hSync/vSync/draw for any resolution and timing,
// drives frame-buffer read addresses (with power-of-two pixel replication) and returns
// the blanked pixel colour. It derives its pixel rate from clk50 through an internal tick
// divider. Sits between the screen memory (port B, read-only) and the VGA pins.
// PARAMETERS
// H_ACTIVE 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48  (pixel ticks)
// V_ACTIVE 480 visible lines;        V_FP 10;  V_SYNC 2;   V_BP 33  (lines)
// CLK_DIV      2  clk50 cycles per pixel tick (>=1)
// SCALE_SHIFT  1  pixel replication: memory x = hcount>>S, y = vcount>>S
// COLOR_BITS   3  colour width ({r,g,b} for 3)
// MEM_LAT      1  memory read latency in clk50 cycles; must satisfy MEM_LAT < CLK_DIV
// HS_POL/VS_POL 0 sync active level (0 = active-low)
// Derived: X_AW = clog2(H_ACTIVE>>S), Y_AW = clog2(V_ACTIVE>>S), ADDR_W = X_AW+Y_AW
// PORTS
// clk50        in   1           system clock; sole clock
// reset        in   1           synchronous, active-low reset
// enable       in   1           scan enable; low = blank, counters held at 0
// mem_addr     out  ADDR_W      read address {y_mem, x_mem}
// mem_data     in   COLOR_BITS  read data, valid MEM_LAT cycles after mem_addr changes
// pixel        out  COLOR_BITS  colour to DAC/pins; 0 outside active area
// draw         out  1           high in visible area (aligned with pixel)
// hSync        out  1           horizontal sync, level per HS_POL
// vSync        out  1           vertical sync, level per VS_POL
// frame_start  out  1           one clk50 pulse on the tick entering (h=0,v=0)
// BEHAVIOUR
// - Reset (reset==0 at clk50 edge): tick counter, hcount, vcount, mem_addr, pixel, draw,
//   frame_start := 0; hSync := ~HS_POL, vSync := ~VS_POL. Reset dominates enable.
// - Tick: asserted one clk50 cycle every CLK_DIV cycles (every cycle if CLK_DIV==1);
//   first tick CLK_DIV-1 cycles after reset release / enable rise.
// - Counters advance only on tick: hcount 0..H_TOTAL-1 then wraps to 0 and vcount++;
//   vcount 0..V_TOTAL-1 then wraps. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V likewise.
// - mem_addr is registered on every tick from the *next* counter values:
//   {vnext>>S, hnext>>S}, truncated to X_AW/Y_AW; during blanking it holds its last value.
// - Output stage (registered on tick, one pixel period after the counter state it shows):
//   draw = (h<H_ACTIVE)&&(v<V_ACTIVE); pixel = draw ? mem_data : 0;
//   hSync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL;
//   vSync same on v with V_ACTIVE/V_FP/V_SYNC. All five outputs change on the same edge.
// - mem_data sampled on the tick edge; MEM_LAT<CLK_DIV guarantees it is valid.
// - frame_start: high exactly one clk50 cycle, the cycle after the tick whose output
//   stage shows h=0,v=0; low otherwise.
// - enable low: on next clk50 edge counters/tick := 0, draw/pixel := 0, syncs inactive,
//   mem_addr := 0; scanning restarts at (0,0) when enable returns high.
// - Reset or enable drop mid-line/mid-frame: no partial sync pulse survives; syncs go
//   inactive on that edge.
// TESTING
// 1 Reset held low 5 cycles, enable=1 -> pixel=0, draw=0, hSync=vSync=1, mem_addr=0.
// 2 Defaults, 2 full lines -> hSync low 192 clk50 cycles, period 1600; draw high 1280.
// 3 Defaults, 2 frames -> vSync low 2 lines (3200 cycles), frame period 840000 cycles;
//   frame_start pulses once per frame, width 1 cycle.
// 4 Memory model data=addr[2:0], MEM_LAT=1 -> at output h=5,v=3 pixel = mem value for
//   addr {1,2}; pixel=0 for all h>=640 or v>=480.
// 5 Assert reset at h=400,v=100 for 1 cycle -> next edge all outputs at reset values;
//   after release first hSync pulse starts exactly 656 ticks later.
// 6 CLK_DIV=1, MEM_LAT=0, SCALE_SHIFT=0, H_ACTIVE=8,V_ACTIVE=4 small timings; toggle
//   enable low mid-frame -> syncs inactive next cycle, restart from (0,0).

Source files
------------

// File: rtl/vga_scan_engine.sv
// VGA scan engine: pixel-tick divider, h/v scan counters, frame-buffer read addressing
// with power-of-two pixel replication, and a registered sync/draw/pixel output stage.
module vga_scan_engine #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int CLK_DIV     = 2,
   parameter int SCALE_SHIFT = 1,
   parameter int COLOR_BITS  = 3,
   parameter int MEM_LAT     = 1,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   localparam int X_AW       = $clog2(H_ACTIVE >> SCALE_SHIFT),
   localparam int Y_AW       = $clog2(V_ACTIVE >> SCALE_SHIFT),
   localparam int ADDR_W     = X_AW + Y_AW
) (
   input  logic                  clk50,
   input  logic                  reset,
   input  logic                  enable,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [COLOR_BITS-1:0] mem_data,
   output logic [COLOR_BITS-1:0] pixel,
   output logic                  draw,
   output logic                  hSync,
   output logic                  vSync,
   output logic                  frame_start
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int TW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

   logic [TW-1:0]   tick_cnt;
   logic            tick;
   logic [HW-1:0]   h_cnt, h_next;
   logic [VW-1:0]   v_cnt, v_next;
   logic [X_AW-1:0] x_next;
   logic [Y_AW-1:0] y_next;
   logic            active_next;
   logic            draw_cur;
   logic            hs_cur;
   logic            vs_cur;

   assign tick = (tick_cnt == TW'(CLK_DIV - 1));

   always_comb begin
      h_next = h_cnt;
      v_next = v_cnt;
      if (h_cnt == HW'(H_TOTAL - 1)) begin
         h_next = '0;
         v_next = (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
      end else begin
         h_next = h_cnt + 1'b1;
      end
   end

   // Replication: the memory sees the scan position divided by 2**SCALE_SHIFT.
   assign x_next      = X_AW'(h_next >> SCALE_SHIFT);
   assign y_next      = Y_AW'(v_next >> SCALE_SHIFT);
   assign active_next = (h_next < HW'(H_ACTIVE)) && (v_next < VW'(V_ACTIVE));

   assign draw_cur = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
   assign hs_cur   = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
   assign vs_cur   = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));

   always_ff @(posedge clk50) begin
      if (!reset || !enable) begin
         tick_cnt    <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         mem_addr    <= '0;
         pixel       <= '0;
         draw        <= 1'b0;
         hSync       <= ~HS_POL;
         vSync       <= ~VS_POL;
         frame_start <= 1'b0;
      end else begin
         tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
         frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
         if (tick) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
            // Address leads the counters by one pixel period so data is ready at the next tick.
            if (active_next)
               mem_addr <= {y_next, x_next};
            draw  <= draw_cur;
            pixel <= draw_cur ? mem_data : '0;
            hSync <= hs_cur ? HS_POL : ~HS_POL;
            vSync <= vs_cur ? VS_POL : ~VS_POL;
         end
      end
   end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench: default 640x480 instance (line timing, pixel fetch, reset mid-sync)
// and a tiny CLK_DIV=1 instance (frame timing, enable drop mid-frame).
module tb_vga_scan_engine;

   logic clk = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // default instance
   logic        rst_d, en_d;
   logic [16:0] addr_d;
   logic [2:0]  mem_d = '0;
   logic [2:0]  pix_d;
   logic        dr_d, hs_d, vs_d, fs_d;

   always @(posedge clk) mem_d <= addr_d[2:0];

   vga_scan_engine u_def (
      .clk50(clk), .reset(rst_d), .enable(en_d), .mem_addr(addr_d), .mem_data(mem_d),
      .pixel(pix_d), .draw(dr_d), .hSync(hs_d), .vSync(vs_d), .frame_start(fs_d)
   );

   // small instance: H 8+2+3+1=14, V 4+1+2+1=8 lines, 112 cycles/frame
   logic       rst_s, en_s;
   logic [4:0] addr_s;
   logic [2:0] mem_s;
   logic [2:0] pix_s;
   logic       dr_s, hs_s, vs_s, fs_s;

   assign mem_s = addr_s[2:0] ^ {1'b0, addr_s[4:3]};

   vga_scan_engine #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(1), .SCALE_SHIFT(0), .COLOR_BITS(3), .MEM_LAT(0)
   ) u_small (
      .clk50(clk), .reset(rst_s), .enable(en_s), .mem_addr(addr_s), .mem_data(mem_s),
      .pixel(pix_s), .draw(dr_s), .hSync(hs_s), .vSync(vs_s), .frame_start(fs_s)
   );

   localparam int FS_D = 0, HS_D = 1, DR_D = 2, FS_S = 3, VS_S = 4;

   function automatic logic sig(input int sel);
      case (sel)
         FS_D:    return fs_d;
         HS_D:    return hs_d;
         DR_D:    return dr_d;
         FS_S:    return fs_s;
         VS_S:    return vs_s;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Returns cyc at the first negedge where the signal has the level, -1 on timeout.
   task automatic wait_level(input int sel, input logic val, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sig(sel) === val) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   initial begin
      int t0, t1, rel, a, b, a2, a3, d0, d1, d2;
      int s0, s1, s2, f, g;
      rst_d = 1'b0; en_d = 1'b1;
      rst_s = 1'b0; en_s = 1'b1;
      repeat (5) @(negedge clk);

      check("rst_pixel",  32'(pix_d),  0);
      check("rst_draw",   32'(dr_d),   0);
      check("rst_hsync",  32'(hs_d),   1);
      check("rst_vsync",  32'(vs_d),   1);
      check("rst_addr",   32'(addr_d), 0);
      check("rst_fs",     32'(fs_d),   0);
      check("rst_s_hs",   32'(hs_s),   1);
      check("rst_s_vs",   32'(vs_s),   1);

      // ---------------- small instance ----------------
      rst_s = 1'b1; rel = cyc;
      wait_level(FS_S, 1'b1, 10, s0);
      check("s_first_tick", 32'(s0 - rel), 1);
      @(negedge clk);
      check("s_fs_width", 32'(fs_s), 0);
      wait_until(s0 + 24);
      check("s_hs_10_1", 32'(hs_s), 0);
      wait_until(s0 + 31);
      check("s_pix_3_2",  32'(pix_s), 1);
      check("s_draw_3_2", 32'(dr_s),  1);
      wait_until(s0 + 49);
      check("s_pix_7_3", 32'(pix_s), 4);
      wait_until(s0 + 56);
      check("s_draw_0_4", 32'(dr_s),  0);
      check("s_pix_0_4",  32'(pix_s), 0);
      wait_level(VS_S, 1'b0, 100, f);
      check("s_vs_start", 32'(f - s0), 70);
      wait_level(VS_S, 1'b1, 100, g);
      check("s_vs_width", 32'(g - f), 28);
      wait_level(FS_S, 1'b1, 100, s1);
      check("s_frame_period", 32'(s1 - s0), 112);
      wait_until(s1 + 81);
      check("s_pre_hs", 32'(hs_s), 0);
      check("s_pre_vs", 32'(vs_s), 0);
      en_s = 1'b0;
      @(negedge clk);
      check("s_en_hs",   32'(hs_s),   1);
      check("s_en_vs",   32'(vs_s),   1);
      check("s_en_draw", 32'(dr_s),   0);
      check("s_en_pix",  32'(pix_s),  0);
      check("s_en_addr", 32'(addr_s), 0);
      repeat (2) @(negedge clk);
      check("s_en_fs", 32'(fs_s), 0);
      en_s = 1'b1; rel = cyc;
      wait_level(FS_S, 1'b1, 10, s2);
      check("s_restart", 32'(s2 - rel), 1);
      wait_until(s2 + 31);
      check("s_restart_pix", 32'(pix_s), 1);

      // ---------------- default instance ----------------
      rst_d = 1'b1; rel = cyc;
      wait_level(FS_D, 1'b1, 10, t0);
      check("d_first_tick", 32'(t0 - rel), 2);
      check("d_draw_0_0",   32'(dr_d), 1);
      @(negedge clk);
      check("d_fs_width", 32'(fs_d), 0);
      wait_level(DR_D, 1'b0, 1400, d0);
      check("d_draw_len", 32'(d0 - t0), 1280);
      check("d_blank_pix", 32'(pix_d), 0);
      wait_level(HS_D, 1'b0, 100, a);
      check("d_hs_start", 32'(a - t0), 1312);
      wait_level(HS_D, 1'b1, 300, b);
      check("d_hs_width", 32'(b - a), 192);
      wait_level(DR_D, 1'b1, 200, d1);
      check("d_line2_start", 32'(d1 - t0), 1600);
      wait_level(DR_D, 1'b0, 1400, d2);
      check("d_draw_len2", 32'(d2 - d1), 1280);
      wait_level(HS_D, 1'b0, 100, a2);
      check("d_hs_period", 32'(a2 - a), 1600);
      wait_until(t0 + 4810);
      check("d_pix_5_3",  32'(pix_d),  2);
      check("d_draw_5_3", 32'(dr_d),   1);
      check("d_addr_6_3", 32'(addr_d), 515);
      wait_until(t0 + 4812);
      check("d_pix_6_3", 32'(pix_d), 3);
      wait_until(t0 + 4830);
      check("d_pix_15_3", 32'(pix_d), 7);
      wait_until(t0 + 6080);
      check("d_draw_640_3", 32'(dr_d),  0);
      check("d_pix_640_3",  32'(pix_d), 0);
      wait_until(t0 + 6200);
      check("d_pre_hs", 32'(hs_d), 0);
      rst_d = 1'b0;
      @(negedge clk);
      check("d_mid_hs",   32'(hs_d),   1);
      check("d_mid_vs",   32'(vs_d),   1);
      check("d_mid_draw", 32'(dr_d),   0);
      check("d_mid_pix",  32'(pix_d),  0);
      check("d_mid_addr", 32'(addr_d), 0);
      check("d_mid_fs",   32'(fs_d),   0);
      rst_d = 1'b1; rel = cyc;
      wait_level(FS_D, 1'b1, 10, t1);
      check("d_rerun_tick", 32'(t1 - rel), 2);
      wait_level(HS_D, 1'b0, 1400, a3);
      check("d_rerun_hs", 32'(a3 - t1), 1312);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
